// File: rtl/updown_dir_ctrl.sv
// Direction control for a 3-bit up/down counter: debounces a pushbutton to toggle
// the count direction, and optionally reverses at the count extremes (ping-pong).
module updown_dir_ctrl #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic INIT_DIR        = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       pingpong_en,
    input  logic [2:0] count,
    output logic       up_down,
    output logic       dir_toggled,
    output logic       btn_db
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CONFIRM,
        HELD,
        RELEASE_CONFIRM
    } state_t;

    // A change is accepted on the cycle the counter would reach DEBOUNCE_CYCLES.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       r_s1;
    logic       r_s2;
    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_up_down;
    logic       r_dir_toggled;
    logic       r_btn_db;

    logic w_press_done;
    logic w_release_done;
    logic w_reverse;
    logic w_flip;

    assign w_press_done   = (r_state == PRESS_CONFIRM)   &&  r_s2 && (r_cnt == CNT_LAST);
    assign w_release_done = (r_state == RELEASE_CONFIRM) && !r_s2 && (r_cnt == CNT_LAST);
    assign w_reverse      = pingpong_en &&
                            (r_up_down ? (count >= 3'd6) : (count <= 3'd1));

    // NOTE: press and end-reversal are OR-ed into one flip so a coincident pair
    // inverts the direction once rather than cancelling out.
    assign w_flip = w_press_done | w_reverse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1          <= 1'b0;
            r_s2          <= 1'b0;
            r_state       <= RELEASED;
            r_cnt         <= 8'd0;
            r_up_down     <= INIT_DIR;
            r_dir_toggled <= 1'b0;
            r_btn_db      <= 1'b0;
        end else begin
            r_s1          <= btn_raw;
            r_s2          <= r_s1;
            r_up_down     <= r_up_down ^ w_flip;
            r_dir_toggled <= w_flip;

            case (r_state)
                RELEASED: begin
                    if (r_s2) begin
                        r_state <= PRESS_CONFIRM;
                        r_cnt   <= 8'd1;
                    end
                end
                PRESS_CONFIRM: begin
                    if (!r_s2) begin
                        r_state <= RELEASED;
                        r_cnt   <= 8'd0;
                    end else if (w_press_done) begin
                        r_state  <= HELD;
                        r_cnt    <= 8'd0;
                        r_btn_db <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                HELD: begin
                    if (!r_s2) begin
                        r_state <= RELEASE_CONFIRM;
                        r_cnt   <= 8'd1;
                    end
                end
                RELEASE_CONFIRM: begin
                    if (r_s2) begin
                        r_state <= HELD;
                        r_cnt   <= 8'd0;
                    end else if (w_release_done) begin
                        r_state  <= RELEASED;
                        r_cnt    <= 8'd0;
                        r_btn_db <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= RELEASED;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    assign up_down     = r_up_down;
    assign dir_toggled = r_dir_toggled;
    assign btn_db      = r_btn_db;

endmodule

// File: tb/tb_updown_dir_ctrl.sv
// Directed bench for updown_dir_ctrl: reset, debounce, bounce rejection, ping-pong
// against a modelled 3-bit up/down counter, collision and mid-press reset.
module tb_updown_dir_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_raw;
    logic       pingpong_en;
    logic [2:0] count;
    logic       up_down;
    logic       dir_toggled;
    logic       btn_db;

    // Downstream counter model; count is either forced or taken from it.
    logic       cnt_run;
    logic       ctr_clr;
    logic [2:0] ctr_q;
    logic [2:0] cnt_force;

    int n_total;
    int n_pass;
    int pulses;

    updown_dir_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .INIT_DIR       (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .pingpong_en(pingpong_en),
        .count      (count),
        .up_down    (up_down),
        .dir_toggled(dir_toggled),
        .btn_db     (btn_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (ctr_clr)      ctr_q <= 3'd0;
        else if (cnt_run) ctr_q <= up_down ? ctr_q + 3'd1 : ctr_q - 3'd1;
    end

    assign count = cnt_run ? ctr_q : cnt_force;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outs(input string tag, input logic ud, input logic db, input logic dt);
        check({tag, ".up_down"}, {7'd0, up_down}, {7'd0, ud});
        check({tag, ".btn_db"}, {7'd0, btn_db}, {7'd0, db});
        check({tag, ".dir_toggled"}, {7'd0, dir_toggled}, {7'd0, dt});
    endtask

    logic [2:0] pp_cnt [16];
    logic       pp_ud  [16];

    initial begin
        n_total     = 0;
        n_pass      = 0;
        rst         = 1'b1;
        btn_raw     = 1'b1;
        pingpong_en = 1'b0;
        cnt_run     = 1'b0;
        ctr_clr     = 1'b0;
        cnt_force   = 3'd0;

        pp_cnt = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                   3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
        pp_ud  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset held for two cycles with the button toggling.
        tick(1);
        check_outs("rst0", 1'b1, 1'b0, 1'b0);
        btn_raw = 1'b0;
        tick(1);
        check_outs("rst1", 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        tick(4);
        check_outs("post_rst", 1'b1, 1'b0, 1'b0);

        // Clean press: btn high before edge 0, toggle lands on edge 5.
        btn_raw = 1'b1;
        tick(5);
        check_outs("press_e4", 1'b1, 1'b0, 1'b0);
        tick(1);
        check_outs("press_e5", 1'b0, 1'b1, 1'b1);
        tick(1);
        check_outs("press_e6", 1'b0, 1'b1, 1'b0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (dir_toggled) pulses++;
        end
        check("hold_pulses", 8'(pulses), 8'd0);
        check_outs("hold_end", 1'b0, 1'b1, 1'b0);

        // Release: btn_db falls at edge 5 with no direction change.
        btn_raw = 1'b0;
        tick(5);
        check_outs("rel_e4", 1'b0, 1'b1, 1'b0);
        tick(1);
        check_outs("rel_e5", 1'b0, 1'b0, 1'b0);

        // Bounce: 3-cycle highs separated by single lows never confirm.
        pulses = 0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                btn_raw = (j != 3);
                tick(1);
                if (dir_toggled || btn_db) pulses++;
            end
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (dir_toggled || btn_db) pulses++;
        end
        check("bounce_activity", 8'(pulses), 8'd0);
        check_outs("bounce_end", 1'b0, 1'b0, 1'b0);

        // Stable second press restores up, exactly one pulse.
        btn_raw = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (dir_toggled) pulses++;
        end
        check("press2_pulses", 8'(pulses), 8'd1);
        check_outs("press2_end", 1'b1, 1'b1, 1'b0);
        btn_raw = 1'b0;
        tick(10);
        check_outs("rel2_end", 1'b1, 1'b0, 1'b0);

        // Ping-pong with the counter in the loop, starting at 0 going up.
        ctr_clr = 1'b1;
        tick(1);
        ctr_clr     = 1'b0;
        cnt_run     = 1'b1;
        pingpong_en = 1'b1;
        check("pp_cnt0", {5'd0, count}, {5'd0, pp_cnt[0]});
        for (int i = 1; i < 16; i++) begin
            tick(1);
            check($sformatf("pp_cnt%0d", i), {5'd0, count}, {5'd0, pp_cnt[i]});
            check($sformatf("pp_ud%0d", i), {7'd0, up_down}, {7'd0, pp_ud[i]});
        end

        // Collision: press confirm on the same edge as the top-end reversal.
        cnt_run   = 1'b0;
        cnt_force = 3'd3;
        btn_raw   = 1'b1;
        tick(5);
        check_outs("coll_pre", 1'b1, 1'b0, 1'b0);
        cnt_force = 3'd6;
        tick(1);
        check_outs("coll_edge", 1'b0, 1'b1, 1'b1);
        cnt_force = 3'd3;
        tick(1);
        check_outs("coll_after", 1'b0, 1'b1, 1'b0);
        pingpong_en = 1'b0;
        btn_raw     = 1'b0;
        tick(10);
        check_outs("coll_rel", 1'b0, 1'b0, 1'b0);

        // Reset in PRESS_CONFIRM with cnt=3, then a full re-confirmation.
        btn_raw = 1'b1;
        tick(5);
        check_outs("mid_pre", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick(1);
        check_outs("mid_rst", 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        tick(5);
        check_outs("mid_e10", 1'b1, 1'b0, 1'b0);
        tick(1);
        check_outs("mid_e11", 1'b0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
